// File: rtl/scaler_pkg.sv
// Shared constants, types and helpers for the vertical scaler:
// 1.12 blend coefficients, the accumulator type and the step clamp.
package scaler_pkg;

   localparam int COEF_W    = 12;
   localparam int COEF_ONE  = 4096;
   localparam int COEF_HALF = 2048;

   // Blend weight in 1.12 format, range 0..4096.
   typedef logic [COEF_W:0] coef_t;

   // Per-channel accumulator; wide enough for DATA_WIDTH up to 18 bits.
   typedef logic [31:0] blend_acc_t;

   // Steps below one input line per output line would need upscaling.
   function automatic logic [15:0] step_clamp(input logic [15:0] step, input logic [15:0] step_min);
      logic [15:0] r;
      if (step < step_min) begin
         r = step_min;
      end else begin
         r = step;
      end
      return r;
   endfunction

endpackage

// File: rtl/scaler_line_ram.sv
// Single-clock line buffer; read-first, so a read and a write to the same
// address in one cycle return the old contents one cycle later.
module scaler_line_ram #(
   parameter int DEPTH = 1024,
   parameter int WIDTH = 8,
   parameter int AW    = 10
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    addr,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // Read-first RAM port.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/scaler_v_lerp.sv
// Vertical down-scaler: blends each input line with the previous one and
// emits only lines on the scaled grid, with a fixed 4-cycle latency.
module scaler_v_lerp
   import scaler_pkg::*;
#(
   parameter int CHANNELS      = 1,
   parameter int DATA_WIDTH    = 8,
   parameter int LINE_SIZE_MAX = 1024,
   parameter int LINE_STEP     = 4096
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [15:0]                    scale_step,
   input  logic                           interp_en,
   input  logic [CHANNELS*DATA_WIDTH-1:0] di_i,
   input  logic                           de_i,
   input  logic                           hs_i,
   input  logic                           vs_i,
   output logic [CHANNELS*DATA_WIDTH-1:0] do_o,
   output logic                           de_o,
   output logic                           hs_o,
   output logic                           vs_o
);

   localparam int DW     = CHANNELS * DATA_WIDTH;
   localparam int AW     = (LINE_SIZE_MAX > 1) ? $clog2(LINE_SIZE_MAX) : 1;
   localparam int PROD_W = DATA_WIDTH + COEF_W + 1;

   logic          hs_d;
   logic          armed;
   logic          emit;
   logic          interp;
   logic [11:0]   line_cnt;
   logic [23:0]   y_next;
   logic [15:0]   step_eff;
   coef_t         f;
   logic [15:0]   x;

   logic          line_start;
   logic          line_end;
   logic [23:0]   y_line;
   logic [23:0]   y_diff;
   logic [10:0]   unused_diff;
   logic          emit_calc;
   logic          emit_now;
   coef_t         f_calc;
   coef_t         f_now;
   logic [15:0]   x_now;
   logic [15:0]   x_next;
   logic          in_range;
   logic          wr_en;
   logic          de_s0;

   logic [DW-1:0] prev;
   logic [DW-1:0] cur1;
   coef_t         f1;
   coef_t         coef_prev;
   logic          near_sel;
   logic          de1, hs1, vs1, interp1;
   logic          de2, hs2, vs2, interp2;
   logic          de3, hs3, vs3;
   logic [DW-1:0] res_all;

   // Line-start decisions take effect on the same cycle as the hs_i falling edge.
   always_comb begin
      line_start  = hs_d & ~hs_i & ~vs_i;
      line_end    = ~hs_d & hs_i;
      y_line      = {line_cnt, 12'd0};
      y_diff      = y_line - y_next;
      unused_diff = y_diff[23:13];
      emit_calc   = armed & (y_next <= y_line);
      f_calc      = coef_t'(COEF_ONE) - y_diff[COEF_W:0];
      if (line_start) begin
         emit_now = emit_calc;
         f_now    = f_calc;
         x_now    = 16'd0;
      end else begin
         emit_now = emit;
         f_now    = f;
         x_now    = x;
      end
      in_range = (x_now < 16'(LINE_SIZE_MAX));
      wr_en    = de_i & in_range;
      de_s0    = wr_en & emit_now & ~vs_i;
      if (de_i && (x_now != 16'hFFFF)) begin
         x_next = x_now + 16'd1;
      end else begin
         x_next = x_now;
      end
   end

   // Frame and line bookkeeping; armed stays low after reset until a frame starts.
   always_ff @(posedge clk) begin
      if (rst) begin
         hs_d     <= 1'b1;
         armed    <= 1'b0;
         emit     <= 1'b0;
         interp   <= 1'b1;
         line_cnt <= 12'd0;
         y_next   <= 24'd0;
         step_eff <= 16'(LINE_STEP);
         f        <= coef_t'(COEF_ONE);
         x        <= 16'd0;
      end else begin
         hs_d <= hs_i;
         x    <= x_next;
         if (vs_i) begin
            armed    <= 1'b1;
            emit     <= 1'b0;
            line_cnt <= 12'd0;
            y_next   <= 24'd0;
            step_eff <= step_clamp(scale_step, 16'(LINE_STEP));
            interp   <= interp_en;
         end else begin
            if (line_start) begin
               emit <= emit_calc;
               f    <= f_calc;
            end
            if (line_end) begin
               line_cnt <= line_cnt + 12'd1;
               if (emit) begin
                  y_next <= y_next + {8'd0, step_eff};
               end
            end
         end
      end
   end

   scaler_line_ram #(
      .DEPTH (LINE_SIZE_MAX),
      .WIDTH (DW),
      .AW    (AW)
   ) u_line_ram (
      .clk   (clk),
      .we    (wr_en),
      .addr  (x_now[AW-1:0]),
      .wdata (di_i),
      .rdata (prev)
   );

   // S1: capture the current pixel alongside the RAM read.
   always_ff @(posedge clk) begin
      if (rst) begin
         cur1    <= '0;
         f1      <= coef_t'(COEF_ONE);
         interp1 <= 1'b1;
         de1     <= 1'b0;
         hs1     <= 1'b1;
         vs1     <= 1'b1;
      end else begin
         cur1    <= di_i;
         f1      <= f_now;
         interp1 <= interp;
         de1     <= de_s0;
         hs1     <= hs_i;
         vs1     <= vs_i;
      end
   end

   assign coef_prev = coef_t'(COEF_ONE) - f1;
   assign near_sel  = (f1 >= coef_t'(COEF_HALF));

   // S2/S3 control pipeline.
   always_ff @(posedge clk) begin
      if (rst) begin
         interp2 <= 1'b1;
         de2     <= 1'b0;
         hs2     <= 1'b1;
         vs2     <= 1'b1;
         de3     <= 1'b0;
         hs3     <= 1'b1;
         vs3     <= 1'b1;
      end else begin
         interp2 <= interp1;
         de2     <= de1;
         hs2     <= hs1;
         vs2     <= vs1;
         de3     <= de2;
         hs3     <= hs2;
         vs3     <= vs2;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [DATA_WIDTH-1:0] prev_c;
      logic [DATA_WIDTH-1:0] cur_c;
      logic [DATA_WIDTH-1:0] near2;
      logic [DATA_WIDTH-1:0] res3;
      logic [PROD_W-1:0]     pp2;
      logic [PROD_W-1:0]     pc2;
      blend_acc_t            sum;
      logic [31-DATA_WIDTH:0] unused_sum;

      assign prev_c     = prev[c*DATA_WIDTH +: DATA_WIDTH];
      assign cur_c      = cur1[c*DATA_WIDTH +: DATA_WIDTH];
      assign sum        = blend_acc_t'(pp2) + blend_acc_t'(pc2) + blend_acc_t'(COEF_HALF);
      assign unused_sum = {sum[31:COEF_W+DATA_WIDTH], sum[COEF_W-1:0]};

      // S2 multiply / nearest pick, S3 round; the weighted sum never exceeds full scale.
      always_ff @(posedge clk) begin
         if (rst) begin
            pp2   <= '0;
            pc2   <= '0;
            near2 <= '0;
            res3  <= '0;
         end else begin
            pp2   <= {{(COEF_W+1){1'b0}}, prev_c} * {{DATA_WIDTH{1'b0}}, coef_prev};
            pc2   <= {{(COEF_W+1){1'b0}}, cur_c} * {{DATA_WIDTH{1'b0}}, f1};
            near2 <= near_sel ? cur_c : prev_c;
            res3  <= interp2 ? sum[COEF_W +: DATA_WIDTH] : near2;
         end
      end

      assign res_all[c*DATA_WIDTH +: DATA_WIDTH] = res3;
   end

   // S4: output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         do_o <= '0;
         de_o <= 1'b0;
         hs_o <= 1'b1;
         vs_o <= 1'b1;
      end else begin
         if (de3) begin
            do_o <= res_all;
         end
         de_o <= de3;
         hs_o <= hs3;
         vs_o <= vs3;
      end
   end

endmodule

// File: tb/tb_scaler_v_lerp.sv
// Directed bench for scaler_v_lerp (3 channels, 8 bits, 1024-pixel line):
// hand-computed expected pixel streams compared against a captured output queue.
`timescale 1ns/1ps
module tb_scaler_v_lerp;

   localparam int W = 24;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   scale_step;
   logic          interp_en;
   logic [W-1:0]  di_i;
   logic          de_i;
   logic          hs_i;
   logic          vs_i;
   logic [W-1:0]  do_o;
   logic          de_o;
   logic          hs_o;
   logic          vs_o;

   int n_vec = 0;
   int n_err = 0;
   logic [W-1:0] out_q[$];
   logic [W-1:0] exp_q[$];
   int neg_cnt = 0;
   int first_de_i = -1;
   int first_de_o = -1;
   int hs_rises = 0;
   logic hs_o_prev = 1'b1;

   always #5 clk = ~clk;

   scaler_v_lerp #(
      .CHANNELS      (3),
      .DATA_WIDTH    (8),
      .LINE_SIZE_MAX (1024),
      .LINE_STEP     (4096)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .scale_step (scale_step),
      .interp_en  (interp_en),
      .di_i       (di_i),
      .de_i       (de_i),
      .hs_i       (hs_i),
      .vs_i       (vs_i),
      .do_o       (do_o),
      .de_o       (de_o),
      .hs_o       (hs_o),
      .vs_o       (vs_o)
   );

   // Output monitor on the inactive edge.
   always @(negedge clk) begin
      neg_cnt++;
      if (de_i && first_de_i < 0) first_de_i = neg_cnt;
      if (de_o) begin
         out_q.push_back(do_o);
         if (first_de_o < 0) first_de_o = neg_cnt;
      end
      if (hs_o && !hs_o_prev) hs_rises++;
      hs_o_prev = hs_o;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [W-1:0] pix(input int pat, input int ln, input int x);
      logic [7:0] v;
      case (pat)
         0:       v = 8'(ln * 8 + x);
         1:       v = 8'(10 * (ln + 1));
         3:       v = 8'(x);
         default: v = 8'd0;
      endcase
      if (pat == 2) begin
         case (ln)
            0:       return {8'd7, 8'd8, 8'd9};
            1:       return {8'd100, 8'd255, 8'd0};
            default: return {8'd100, 8'd254, 8'd1};
         endcase
      end
      return {v, v, v};
   endfunction

   function automatic logic [W-1:0] rep(input logic [7:0] v);
      return {v, v, v};
   endfunction

   task automatic frame_start(input logic [15:0] step, input logic ie);
      vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b0;
      scale_step = step; interp_en = ie;
      repeat (3) tick();
      vs_i = 1'b0;
      repeat (2) tick();
   endtask

   task automatic send_line(input int pat, input int ln, input int npix, input int gap);
      hs_i = 1'b0;
      for (int x = 0; x < npix; x++) begin
         de_i = 1'b1;
         di_i = pix(pat, ln, x);
         tick();
         if (gap > 0) begin
            de_i = 1'b0;
            repeat (gap) tick();
         end
      end
      de_i = 1'b0;
      tick();
      hs_i = 1'b1;
      repeat (4) tick();
   endtask

   task automatic cmp_q(input string tag);
      chk({tag, "_count"}, 32'(out_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++)
         chk($sformatf("%s_px%0d", tag, i), 32'(out_q[i]), 32'(exp_q[i]));
      out_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int vals_lin [5];
      int vals_near [5];
      vals_lin  = '{10, 25, 40, 55, 70};
      vals_near = '{10, 30, 40, 60, 70};

      rst = 1'b1; vs_i = 1'b1; hs_i = 1'b1; de_i = 1'b0; di_i = '0;
      scale_step = 16'd4096; interp_en = 1'b1;
      repeat (3) tick();
      chk("reset_do",  32'(do_o), 32'd0);
      chk("reset_de",  32'(de_o), 32'd0);
      chk("reset_hs",  32'(hs_o), 32'd1);
      chk("reset_vs",  32'(vs_o), 32'd1);
      rst = 1'b0;
      tick();
      out_q.delete();

      // 1:1 pass-through, continuous pixels
      first_de_i = -1; first_de_o = -1;
      frame_start(16'd4096, 1'b1);
      for (int ln = 0; ln < 8; ln++) begin
         for (int x = 0; x < 8; x++) exp_q.push_back(pix(0, ln, x));
         send_line(0, ln, 8, 0);
      end
      repeat (8) tick();
      cmp_q("pass");
      chk("pass_latency", 32'(first_de_o - first_de_i), 32'd4);

      // half height
      hs_rises = 0;
      frame_start(16'd8192, 1'b1);
      for (int ln = 0; ln < 8; ln++) begin
         if (ln % 2 == 0)
            for (int x = 0; x < 8; x++) exp_q.push_back(pix(0, ln, x));
         send_line(0, ln, 8, 0);
      end
      repeat (8) tick();
      cmp_q("half");
      chk("half_hs_rises", 32'(hs_rises), 32'd8);

      // fractional step, linear, sparse pixels
      frame_start(16'd6144, 1'b1);
      for (int ln = 0; ln < 8; ln++) send_line(1, ln, 4, 1);
      for (int k = 0; k < 5; k++)
         for (int x = 0; x < 4; x++) exp_q.push_back(rep(8'(vals_lin[k])));
      repeat (8) tick();
      cmp_q("frac_lin");

      // fractional step, nearest
      frame_start(16'd6144, 1'b0);
      for (int ln = 0; ln < 8; ln++) send_line(1, ln, 4, 0);
      for (int k = 0; k < 5; k++)
         for (int x = 0; x < 4; x++) exp_q.push_back(rep(8'(vals_near[k])));
      repeat (8) tick();
      cmp_q("frac_near");

      // rounding across channels at f=2048
      frame_start(16'd6144, 1'b1);
      for (int ln = 0; ln < 3; ln++) send_line(2, ln, 4, 0);
      for (int x = 0; x < 4; x++) exp_q.push_back({8'd7, 8'd8, 8'd9});
      for (int x = 0; x < 4; x++) exp_q.push_back({8'd100, 8'd255, 8'd1});
      repeat (8) tick();
      cmp_q("round");

      // reset in the middle of a line
      frame_start(16'd4096, 1'b1);
      hs_i = 1'b0;
      for (int x = 0; x < 3; x++) begin
         de_i = 1'b1; di_i = pix(0, 0, x); tick();
      end
      rst = 1'b1; di_i = pix(0, 0, 3); tick();
      rst = 1'b0;
      chk("rst_mid_de", 32'(de_o), 32'd0);
      chk("rst_mid_hs", 32'(hs_o), 32'd1);
      chk("rst_mid_vs", 32'(vs_o), 32'd1);
      chk("rst_mid_do", 32'(do_o), 32'd0);
      out_q.delete();
      for (int x = 4; x < 8; x++) begin
         de_i = 1'b1; di_i = pix(0, 0, x); tick();
      end
      de_i = 1'b0; tick();
      hs_i = 1'b1; repeat (4) tick();
      send_line(0, 1, 8, 0);
      repeat (8) tick();
      chk("rst_mid_no_de", 32'(out_q.size()), 32'd0);
      out_q.delete();

      // step below 1.0 clamps to 1:1
      frame_start(16'd2048, 1'b1);
      for (int ln = 0; ln < 2; ln++) begin
         for (int x = 0; x < 8; x++) exp_q.push_back(pix(0, ln, x));
         send_line(0, ln, 8, 0);
      end
      repeat (8) tick();
      cmp_q("clamp");

      // line longer than the buffer
      frame_start(16'd4096, 1'b1);
      for (int x = 0; x < 1024; x++) exp_q.push_back(pix(3, 0, x));
      send_line(3, 0, 1030, 0);
      repeat (8) tick();
      cmp_q("ovf");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/scaler_v_lerp.md
# scaler_v_lerp

Multi-channel vertical down-scaler with 2-tap linear or nearest-line interpolation, the next generation of `scaler_v`. It takes a raster video stream (`di_i`/`de_i`/`hs_i`/`vs_i`), keeps one previous input line in a line buffer, and blends it with the current line. It emits only the output lines that fall on the scaled grid. It sits after the horizontal scaler in the scaler2 pipeline, using the same stream protocol on both sides.

## Interface
- `CHANNELS`, 1: independent colour channels packed in `di_i`/`do_o`, channel c at `[c*DATA_WIDTH +: DATA_WIDTH]`.
- `DATA_WIDTH`, 8: bits per channel.
- `LINE_SIZE_MAX`, 1024: line buffer depth in pixels.
- `LINE_STEP`, 4096: fixed-point value of 1.0 (12 fractional bits).
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `scale_step`, in, 16: unsigned 4.12 vertical step (input lines per output line). Sampled while `vs_i`=1.
- `interp_en`, in, 1: 1 = linear blend, 0 = nearest line. Sampled while `vs_i`=1.
- `di_i`, in, CHANNELS*DATA_WIDTH: pixel data.
- `de_i`, in, 1: pixel valid.
- `hs_i`, in, 1: high between lines.
- `vs_i`, in, 1: high between frames.
- `do_o`, out, CHANNELS*DATA_WIDTH: scaled pixel.
- `de_o`, `hs_o`, `vs_o`, out, 1 each: delayed stream controls.

## Operation
- **Step clamp:** `step_eff` = max(`scale_step`, 4096). Steps below 4096 and a step of 0 behave as 1:1. Upscaling is not supported because the stream has no backpressure.
- **Frame start:** while `vs_i`=1, `line_cnt`=0 (12 bit), `y_next`=0 (24 bit, 12.12 format), and `step_eff` and `interp_en` are latched.
- **Line start** (`hs_i` 1→0):
  - `emit` = (`y_next` ≤ `line_cnt`<<12).
  - `f` = 4096 − ((`line_cnt`<<12) − `y_next`). `f` is 13 bits, range 1..4096.
  - `emit` and `f` are held for the whole line.
- **Line end** (`hs_i` 0→1): `line_cnt`++. If `emit` was set, `y_next` += `step_eff`. At most one output line is produced per input line.
- **Per pixel** (`de_i`=1, x = pixel index in the line, reset at line start):
  - `prev` = line buffer[x], read before write.
  - line buffer[x] = `di_i`.
  - If `emit`:
    - Linear mode: `do_o` = (`prev`*(4096−f) + `cur`*f + 2048) >> 12, per channel.
    - Nearest mode: `do_o` = `cur` if f ≥ 2048, else `prev`.
  - Product width is DATA_WIDTH+13 bits; sum width is DATA_WIDTH+14 bits. The result never exceeds 2^DATA_WIDTH−1, so no saturation is needed.
- **First line:** `f`=4096, so the output equals `cur`. Stale buffer contents are multiplied by 0.
- **Overflow:** pixels with x ≥ LINE_SIZE_MAX are neither written nor emitted (`de_o`=0 for those pixels).
- **Skipped lines:** the buffer is still written; `de_o` stays 0. `hs_o`/`vs_o` still pass through.

## Timing
- Fixed latency of 4 cycles from `di_i`/`de_i`/`hs_i`/`vs_i` to the corresponding output:
  - S1: RAM read, capture `cur`.
  - S2: multiply.
  - S3: sum and round.
  - S4: output register.
- `hs_o`/`vs_o` are 4-cycle delayed copies of `hs_i`/`vs_i`. `de_o` is the delayed `de_i` AND `emit` AND in-range.
- Full throughput: `de_i` may be high every cycle. Sparse input (gaps between pixels) is preserved on the output.
- Reset values: `do_o`=0, `de_o`=0, `hs_o`=1, `vs_o`=1. The pipeline flushes to idle, and `line_cnt`/`y_next`/`emit` clear.
- Reset mid-line: outputs show idle on the next cycle. The remainder of the line produces no `de_o` until `vs_i`=1 restarts the frame.
- `scale_step` changes mid-frame are ignored until the next `vs_i`=1.

## Structure
- Package `scaler_pkg` holds:
  - `COEF_W`=12 and `COEF_ONE`=4096.
  - The `step_clamp` function.
  - The blend-function typedef for the per-channel accumulator.
- Sub-module `scaler_line_ram`: single-clock RAM, LINE_SIZE_MAX × CHANNELS*DATA_WIDTH, read-first, 1-cycle read latency.
- The blend is a per-channel generate loop inside the top module.

## Test plan
- **1:1 pass-through:** `scale_step`=4096, linear mode, 8×8 ramp, `DE_I_PERIOD`=0. Expect 8 output lines identical to the input, with `de_o` appearing 4 cycles after `de_i`.
- **Half height:** `scale_step`=8192, 8 lines. Expect 4 output lines equal to input lines 0, 2, 4, 6 (f=4096). `hs_o` toggles 8 times.
- **Fractional step:** `scale_step`=6144, 8 lines, line n filled with value 10·(n+1). Expect 5 lines, emitted during input lines 0, 2, 3, 5, 6, with values 10, 25, 40, 55, 70.
- **Nearest mode:** same stimulus with `interp_en`=0. Expect values 10, 30, 40, 60, 70.
- **Rounding and channels:** CHANNELS=3, `prev`={0,255,100}, `cur`={1,254,100}, f=2048. Expect {1,255,100}.
- **Reset mid-line and clamp:** assert `rst` for 1 cycle mid-line; expect idle outputs next cycle and no `de_o` until the next frame. Then `scale_step`=2048; expect 1:1 output. Also send a 1030-pixel line with LINE_SIZE_MAX=1024; expect 1024 `de_o` pulses.
